// File: rtl/ls_queue_if.sv
`default_nettype none
// ============================================================================
// ls_queue_if : memory request/response channel of the load/store queue (rev 1.0)
// ============================================================================
interface ls_queue_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic              mem_req_valid_out;
    logic              mem_req_ready_in;
    logic              mem_req_we_out;
    logic [ADDR_W-1:0] mem_req_addr_out;
    logic [1:0]        mem_req_size_out;
    logic [WORD_W-1:0] mem_req_data_out;
    logic              mem_resp_valid_in;
    logic [WORD_W-1:0] mem_resp_data_in;

    modport master (
        output mem_req_valid_out, mem_req_we_out, mem_req_addr_out,
               mem_req_size_out, mem_req_data_out,
        input  mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in
    );

    modport slave (
        input  mem_req_valid_out, mem_req_we_out, mem_req_addr_out,
               mem_req_size_out, mem_req_data_out,
        output mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in
    );
endinterface
`default_nettype wire

// File: rtl/ls_queue.sv
`default_nettype none
// ============================================================================
// ls_queue : in-order load/store queue with CDB wakeup and commit-gated stores (rev 1.0)
// ============================================================================
module ls_queue #(
    parameter int DEPTH     = 16,
    parameter int ROB_W     = 4,
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int IMM_W     = 12,
    parameter int CDB_PORTS = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        rdy_in,
    input  logic                        flush_in,
    input  logic                        issue_en_in,
    input  logic [2:0]                  issue_op_in,
    input  logic [ROB_W-1:0]            issue_rob_in,
    input  logic [IMM_W-1:0]            issue_imm_in,
    input  logic [ROB_W-1:0]            issue_q1_in,
    input  logic [ROB_W-1:0]            issue_q2_in,
    input  logic [WORD_W-1:0]           issue_v1_in,
    input  logic [WORD_W-1:0]           issue_v2_in,
    output logic                        full_out,
    output logic [$clog2(DEPTH):0]      count_out,
    input  logic [CDB_PORTS-1:0]        cdb_en_in,
    input  logic [CDB_PORTS*ROB_W-1:0]  cdb_rob_in,
    input  logic [CDB_PORTS*WORD_W-1:0] cdb_res_in,
    input  logic                        commit_en_in,
    output logic                        st_ready_en_out,
    output logic [ROB_W-1:0]            st_ready_rob_out,
    output logic                        ld_res_en_out,
    output logic [ROB_W-1:0]            ld_res_rob_out,
    output logic [WORD_W-1:0]           ld_res_data_out,
    ls_queue_if.master                  mem
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_REQ  = 3'd1,
        LD_WAIT = 3'd2,
        ST_CMT  = 3'd3,
        ST_REQ  = 3'd4,
        ST_WAIT = 3'd5
    } state_t;

    logic [2:0]        op_q  [DEPTH];
    logic [ROB_W-1:0]  rob_q [DEPTH];
    logic [IMM_W-1:0]  imm_q [DEPTH];
    logic [ROB_W-1:0]  q1_q  [DEPTH];
    logic [ROB_W-1:0]  q2_q  [DEPTH];
    logic [WORD_W-1:0] v1_q  [DEPTH];
    logic [WORD_W-1:0] v2_q  [DEPTH];

    state_t            state;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              drop;

    // Returns {hit, value}; the queue's own load writeback acts as the lowest-priority channel.
    function automatic logic [WORD_W:0] snoop(input logic [ROB_W-1:0] tag);
        logic [WORD_W:0] res;
        res = '0;
        if (tag != '0) begin
            if (ld_res_en_out && ld_res_rob_out == tag)
                res = {1'b1, ld_res_data_out};
            for (int k = CDB_PORTS - 1; k >= 0; k--)
                if (cdb_en_in[k] && cdb_rob_in[k*ROB_W +: ROB_W] == tag)
                    res = {1'b1, cdb_res_in[k*WORD_W +: WORD_W]};
        end
        return res;
    endfunction

    logic [WORD_W:0] wake1 [DEPTH];
    logic [WORD_W:0] wake2 [DEPTH];
    logic [WORD_W:0] iss1;
    logic [WORD_W:0] iss2;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = snoop(q1_q[i]);
            wake2[i] = snoop(q2_q[i]);
        end
        iss1 = snoop(issue_q1_in);
        iss2 = snoop(issue_q2_in);
    end

    logic [2:0]        h_op;
    logic              h_store;
    logic [1:0]        h_size;
    logic [ADDR_W-1:0] h_addr;
    logic [WORD_W-1:0] ld_ext;

    always_comb begin
        h_op    = op_q[head];
        h_store = h_op >= 3'd5;
        h_addr  = ADDR_W'(v1_q[head]) + ADDR_W'($signed(imm_q[head]));
        case (h_op)
            3'd0, 3'd3, 3'd5: h_size = 2'd0;
            3'd1, 3'd4, 3'd6: h_size = 2'd1;
            default:          h_size = 2'd3;
        endcase
        case (h_op)
            3'd0:    ld_ext = {{(WORD_W-8){mem.mem_resp_data_in[7]}}, mem.mem_resp_data_in[7:0]};
            3'd1:    ld_ext = {{(WORD_W-16){mem.mem_resp_data_in[15]}}, mem.mem_resp_data_in[15:0]};
            3'd3:    ld_ext = {{(WORD_W-8){1'b0}}, mem.mem_resp_data_in[7:0]};
            3'd4:    ld_ext = {{(WORD_W-16){1'b0}}, mem.mem_resp_data_in[15:0]};
            default: ld_ext = mem.mem_resp_data_in;
        endcase
    end

    logic committed;
    logic deq;
    logic enq;

    assign full_out  = count_out == CNT_W'(DEPTH);
    assign committed = (state == ST_REQ) || (state == ST_WAIT);
    assign deq       = mem.mem_resp_valid_in && ((state == LD_WAIT && !drop) || state == ST_WAIT);
    // A slot freed by a same-cycle dequeue may be refilled even when full.
    assign enq       = issue_en_in && !flush_in && (!full_out || deq);

    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wake1[i][WORD_W]) begin
                    q1_q[i] <= '0;
                    v1_q[i] <= wake1[i][WORD_W-1:0];
                end
                if (wake2[i][WORD_W]) begin
                    q2_q[i] <= '0;
                    v2_q[i] <= wake2[i][WORD_W-1:0];
                end
            end
            if (enq) begin
                op_q[tail]  <= issue_op_in;
                rob_q[tail] <= issue_rob_in;
                imm_q[tail] <= issue_imm_in;
                if (issue_q1_in != '0 && iss1[WORD_W]) begin
                    q1_q[tail] <= '0;
                    v1_q[tail] <= iss1[WORD_W-1:0];
                end else begin
                    q1_q[tail] <= issue_q1_in;
                    v1_q[tail] <= issue_v1_in;
                end
                if (issue_q2_in != '0 && iss2[WORD_W]) begin
                    q2_q[tail] <= '0;
                    v2_q[tail] <= iss2[WORD_W-1:0];
                end else begin
                    q2_q[tail] <= issue_q2_in;
                    v2_q[tail] <= issue_v2_in;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state                 <= IDLE;
            head                  <= '0;
            tail                  <= '0;
            count_out             <= '0;
            drop                  <= 1'b0;
            st_ready_en_out       <= 1'b0;
            st_ready_rob_out      <= '0;
            ld_res_en_out         <= 1'b0;
            ld_res_rob_out        <= '0;
            ld_res_data_out       <= '0;
            mem.mem_req_valid_out <= 1'b0;
            mem.mem_req_we_out    <= 1'b0;
            mem.mem_req_addr_out  <= '0;
            mem.mem_req_size_out  <= '0;
            mem.mem_req_data_out  <= '0;
        end else if (rdy_in) begin
            st_ready_en_out <= 1'b0;
            ld_res_en_out   <= 1'b0;

            if (flush_in) begin
                if (committed) begin
                    tail      <= head + PTR_W'(1);
                    if (deq) begin
                        head      <= head + PTR_W'(1);
                        count_out <= '0;
                    end else begin
                        count_out <= CNT_W'(1);
                    end
                end else begin
                    tail      <= head;
                    count_out <= '0;
                end
            end else begin
                if (deq) head <= head + PTR_W'(1);
                if (enq) tail <= tail + PTR_W'(1);
                count_out <= count_out + CNT_W'(enq) - CNT_W'(deq);
            end

            case (state)
                IDLE: begin
                    if (!flush_in && count_out != '0) begin
                        if (!h_store && q1_q[head] == '0) begin
                            state                 <= LD_REQ;
                            mem.mem_req_valid_out <= 1'b1;
                            mem.mem_req_we_out    <= 1'b0;
                            mem.mem_req_addr_out  <= h_addr;
                            mem.mem_req_size_out  <= h_size;
                            mem.mem_req_data_out  <= '0;
                        end else if (h_store && q1_q[head] == '0 && q2_q[head] == '0) begin
                            state            <= ST_CMT;
                            st_ready_en_out  <= 1'b1;
                            st_ready_rob_out <= rob_q[head];
                        end
                    end
                end
                LD_REQ: begin
                    if (flush_in) drop <= 1'b1;
                    if (mem.mem_req_ready_in) begin
                        mem.mem_req_valid_out <= 1'b0;
                        state                 <= LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    if (mem.mem_resp_valid_in) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                        if (!drop && !flush_in) begin
                            ld_res_en_out   <= 1'b1;
                            ld_res_rob_out  <= rob_q[head];
                            ld_res_data_out <= ld_ext;
                        end
                    end else if (flush_in) begin
                        drop <= 1'b1;
                    end
                end
                ST_CMT: begin
                    if (flush_in) begin
                        state <= IDLE;
                    end else if (commit_en_in) begin
                        state                 <= ST_REQ;
                        mem.mem_req_valid_out <= 1'b1;
                        mem.mem_req_we_out    <= 1'b1;
                        mem.mem_req_addr_out  <= h_addr;
                        mem.mem_req_size_out  <= h_size;
                        mem.mem_req_data_out  <= v2_q[head];
                    end
                end
                ST_REQ: begin
                    if (mem.mem_req_ready_in) begin
                        mem.mem_req_valid_out <= 1'b0;
                        state                 <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_resp_valid_in) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_n_in && rdy_in && !flush_in && commit_en_in)
            assert (state == ST_CMT);
    end
endmodule
`default_nettype wire

// File: tb/tb_ls_queue.sv
`default_nettype none
// ============================================================================
// tb_ls_queue : directed self-checking bench for ls_queue (rev 1.0)
// ============================================================================
`timescale 1ns/1ps
module tb_ls_queue;
    localparam int DEPTH = 16, ROB_W = 4, WORD_W = 32, ADDR_W = 32, IMM_W = 12, CDB_PORTS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        issue_en = 1'b0;
    logic [2:0]  issue_op = '0;
    logic [3:0]  issue_rob = '0;
    logic [11:0] issue_imm = '0;
    logic [3:0]  q1 = '0, q2 = '0;
    logic [31:0] v1 = '0, v2 = '0;
    logic        full;
    logic [4:0]  count;
    logic [1:0]  cdb_en = '0;
    logic [7:0]  cdb_rob = '0;
    logic [63:0] cdb_res = '0;
    logic        commit_en = 1'b0;
    logic        st_ready_en;
    logic [3:0]  st_ready_rob;
    logic        ld_res_en;
    logic [3:0]  ld_res_rob;
    logic [31:0] ld_res_data;
    int          checks = 0;
    int          failures = 0;

    ls_queue_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) mif ();

    ls_queue #(
        .DEPTH(DEPTH), .ROB_W(ROB_W), .WORD_W(WORD_W),
        .ADDR_W(ADDR_W), .IMM_W(IMM_W), .CDB_PORTS(CDB_PORTS)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
        .issue_en_in(issue_en), .issue_op_in(issue_op), .issue_rob_in(issue_rob),
        .issue_imm_in(issue_imm), .issue_q1_in(q1), .issue_q2_in(q2),
        .issue_v1_in(v1), .issue_v2_in(v2), .full_out(full), .count_out(count),
        .cdb_en_in(cdb_en), .cdb_rob_in(cdb_rob), .cdb_res_in(cdb_res),
        .commit_en_in(commit_en), .st_ready_en_out(st_ready_en),
        .st_ready_rob_out(st_ready_rob), .ld_res_en_out(ld_res_en),
        .ld_res_rob_out(ld_res_rob), .ld_res_data_out(ld_res_data), .mem(mif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [2:0] op, input logic [3:0] rob, input logic [11:0] imm,
                             input logic [3:0] t1, input logic [31:0] d1,
                             input logic [3:0] t2, input logic [31:0] d2);
        issue_op = op; issue_rob = rob; issue_imm = imm;
        q1 = t1; v1 = d1; q2 = t2; v2 = d2;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] rob, input logic [11:0] imm,
                         input logic [3:0] t1, input logic [31:0] d1,
                         input logic [3:0] t2, input logic [31:0] d2);
        set_issue(op, rob, imm, t1, d1, t2, d2);
        issue_en = 1'b1;
        step();
        issue_en = 1'b0;
    endtask

    task automatic accept();
        mif.mem_req_ready_in = 1'b1;
        step();
        mif.mem_req_ready_in = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        mif.mem_resp_valid_in = 1'b1;
        mif.mem_resp_data_in  = d;
        step();
        mif.mem_resp_valid_in = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] op, input logic [3:0] rob,
                           input logic [31:0] base, input logic [11:0] imm,
                           input logic [31:0] exp_addr, input logic [1:0] exp_size,
                           input logic [31:0] resp, input logic [31:0] exp_data);
        issue(op, rob, imm, 4'd0, base, 4'd0, 32'h0);
        step();
        check({tag, "_valid"}, mif.mem_req_valid_out, 1);
        check({tag, "_addr"}, mif.mem_req_addr_out, exp_addr);
        check({tag, "_size"}, mif.mem_req_size_out, exp_size);
        accept();
        check({tag, "_noearly"}, ld_res_en, 0);
        respond(resp);
        check({tag, "_ld_en"}, ld_res_en, 1);
        check({tag, "_ld_data"}, ld_res_data, exp_data);
        check({tag, "_ld_rob"}, ld_res_rob, rob);
        step();
        check({tag, "_pulse"}, ld_res_en, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mif.mem_req_ready_in  = 1'b0;
        mif.mem_resp_valid_in = 1'b0;
        mif.mem_resp_data_in  = '0;
        step(); step();
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_valid", mif.mem_req_valid_out, 0);
        check("rst_ld_en", ld_res_en, 0);
        check("rst_st_en", st_ready_en, 0);
        rst_n = 1'b1;
        step();

        // T1: LW with negative offset, request held, frozen while rdy is low
        issue(3'd2, 4'd1, 12'hFFC, 4'd0, 32'h100, 4'd0, 32'h0);
        step();
        check("T1_valid", mif.mem_req_valid_out, 1);
        check("T1_addr", mif.mem_req_addr_out, 32'hFC);
        check("T1_size", mif.mem_req_size_out, 3);
        check("T1_we", mif.mem_req_we_out, 0);
        step();
        check("T1_hold_valid", mif.mem_req_valid_out, 1);
        check("T1_hold_addr", mif.mem_req_addr_out, 32'hFC);
        rdy = 1'b0;
        mif.mem_req_ready_in = 1'b1;
        step();
        check("T1_freeze", mif.mem_req_valid_out, 1);
        rdy = 1'b1;
        step();
        mif.mem_req_ready_in = 1'b0;
        check("T1_accepted", mif.mem_req_valid_out, 0);
        respond(32'hDEADBEEF);
        check("T1_ld_en", ld_res_en, 1);
        check("T1_ld_data", ld_res_data, 32'hDEADBEEF);
        check("T1_ld_rob", ld_res_rob, 1);
        step();
        check("T1_pulse", ld_res_en, 0);
        check("T1_count", count, 0);

        // T2: sign and zero extension
        do_load("T2_lb", 3'd0, 4'd2, 32'h10, 12'h001, 32'h11, 2'd0, 32'h80, 32'hFFFFFF80);
        do_load("T2_lbu", 3'd3, 4'd3, 32'h20, 12'h000, 32'h20, 2'd0, 32'h80, 32'h00000080);
        do_load("T2_lh", 3'd1, 4'd4, 32'h30, 12'h002, 32'h32, 2'd1, 32'h8001, 32'hFFFF8001);

        // T3: store waits for data from CDB channel 1, then for commit
        issue(3'd7, 4'd5, 12'h008, 4'd0, 32'h200, 4'd5, 32'h0);
        step();
        check("T3_unresolved", st_ready_en, 0);
        cdb_en  = 2'b10;
        cdb_rob = {4'd5, 4'd0};
        cdb_res = {32'h0000_1234, 32'hFFFF_FFFF};
        step();
        cdb_en = 2'b00;
        check("T3_st_early", st_ready_en, 0);
        step();
        check("T3_st_en", st_ready_en, 1);
        check("T3_st_rob", st_ready_rob, 5);
        step();
        check("T3_st_pulse", st_ready_en, 0);
        step(); step();
        check("T3_nocommit", mif.mem_req_valid_out, 0);
        commit_en = 1'b1;
        step();
        commit_en = 1'b0;
        check("T3_valid", mif.mem_req_valid_out, 1);
        check("T3_we", mif.mem_req_we_out, 1);
        check("T3_data", mif.mem_req_data_out, 32'h1234);
        check("T3_addr", mif.mem_req_addr_out, 32'h208);
        accept();
        check("T3_held", count, 1);
        respond(32'h0);
        check("T3_deq", count, 0);
        check("T3_no_ld", ld_res_en, 0);

        // T4: fill, overfill, then simultaneous enqueue/dequeue while full
        issue_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            set_issue(3'd7, 4'((i % 15) + 1), 12'h000, 4'd0, 32'h300, 4'd7, 32'h0);
            step();
        end
        check("T4_count", count, 16);
        check("T4_full", full, 1);
        set_issue(3'd2, 4'd15, 12'h000, 4'd0, 32'h0, 4'd0, 32'h0);
        step();
        issue_en = 1'b0;
        check("T4_overfill", count, 16);
        check("T4_blocked", st_ready_en, 0);
        cdb_en  = 2'b01;
        cdb_rob = {4'd0, 4'd7};
        cdb_res = {32'h0, 32'hAA};
        step();
        cdb_en = 2'b00;
        step();
        check("T4_st_en", st_ready_en, 1);
        check("T4_st_rob", st_ready_rob, 1);
        commit_en = 1'b1;
        step();
        commit_en = 1'b0;
        check("T4_data", mif.mem_req_data_out, 32'hAA);
        accept();
        set_issue(3'd2, 4'd9, 12'h000, 4'd0, 32'h0, 4'd0, 32'h0);
        issue_en = 1'b1;
        respond(32'h0);
        issue_en = 1'b0;
        check("T4_enqdeq", count, 16);
        check("T4_enqdeq_full", full, 1);

        rst_n = 1'b0;
        #1;
        check("rst2_count", count, 0);
        step();
        rst_n = 1'b1;
        step();

        // T5: flush with a committed store in flight and three younger loads
        issue_en = 1'b1;
        set_issue(3'd7, 4'd3, 12'h000, 4'd0, 32'h400, 4'd0, 32'h55);
        step();
        for (int i = 0; i < 3; i++) begin
            set_issue(3'd2, 4'(4 + i), 12'h000, 4'd0, 32'h500, 4'd0, 32'h0);
            step();
        end
        issue_en = 1'b0;
        check("T5_count", count, 4);
        commit_en = 1'b1;
        step();
        commit_en = 1'b0;
        check("T5_st_data", mif.mem_req_data_out, 32'h55);
        accept();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("T5_flush", count, 1);
        step();
        respond(32'h0);
        check("T5_done", count, 0);
        step(); step();
        check("T5_noyounger", mif.mem_req_valid_out, 0);

        // T6: flush during load wait drops the response and ignores a same-cycle issue
        issue(3'd2, 4'd8, 12'h000, 4'd0, 32'h600, 4'd0, 32'h0);
        step();
        check("T6_valid", mif.mem_req_valid_out, 1);
        accept();
        flush = 1'b1;
        set_issue(3'd2, 4'd9, 12'h000, 4'd0, 32'h680, 4'd0, 32'h0);
        issue_en = 1'b1;
        step();
        flush = 1'b0;
        issue_en = 1'b0;
        check("T6_flush_count", count, 0);
        respond(32'h77);
        check("T6_drop", ld_res_en, 0);
        step();
        check("T6_drop_late", ld_res_en, 0);
        check("T6_noreq", mif.mem_req_valid_out, 0);
        do_load("T6_after", 3'd2, 4'd10, 32'h700, 12'h004, 32'h704, 2'd3, 32'h99, 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
